// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-cycle 32-bit shifter (sll/srl/sra). Applies one fixed
//            power-of-two stage (1,2,4,8,16) per clock under valid/ready
//            handshakes on both operand and result sides.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               busy
);

  localparam int STG_W = 3;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         op;
  logic [STG_W-1:0]   stage;
  logic [WIDTH-1:0]   result;
  logic               err;

  logic [WIDTH-1:0]   stage_out [SHAMT_W];
  logic [WIDTH-1:0]   stage_sel;
  logic               stage_bit;
  logic [WIDTH-1:0]   data_step;
  logic [SHAMT_W-1:0] shamt_hi;
  logic               last_stage;
  logic               bypass;

  // Fixed-wiring shift stages, one per power of two.
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int AMT = 1 << i;
    logic signed [WIDTH-1:0] sra_v;
    assign sra_v = $signed(data) >>> AMT;
    assign stage_out[i] = (op == OP_SLL) ? (data << AMT) :
                          (op == OP_SRA) ? WIDTH'(sra_v) :
                                           (data >> AMT);
  end

  // Pick the active stage output and its shift-amount bit.
  always_comb begin
    stage_sel = data;
    stage_bit = 1'b0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (int'(stage) == i) begin
        stage_sel = stage_out[i];
        stage_bit = shamt[i];
      end
    end
  end

  assign data_step  = stage_bit ? stage_sel : data;
  assign shamt_hi   = shamt >> (stage + STG_W'(1));
  assign last_stage = (shamt_hi == '0);
  assign bypass     = (in_op == OP_RSV) || (in_shamt == '0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; trailing zero stages end the shift early.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = bypass ? DONE : SHIFT;
      SHIFT:   if (last_stage) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-stage datapath update and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data   <= '0;
      shamt  <= '0;
      op     <= '0;
      stage  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= in_data;
            shamt <= in_shamt;
            op    <= in_op;
            stage <= '0;
            if (bypass) begin
              result <= in_data;
              err    <= (in_op == OP_RSV);
            end
          end
        end
        SHIFT: begin
          data  <= data_step;
          stage <= stage + STG_W'(1);
          if (last_stage) begin
            result <= data_step;
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = result;
  assign out_err   = err;

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle 32-bit shifter controller for the ALU shift path.
- Applies one fixed power-of-two shift stage per clock: 1, 2, 4, 8, then 16. Each stage is the same fixed-wiring kind as the team's constant left-shift stages, with right-shift equivalents.
- This trades the full combinational barrel shifter for area. Operands enter over a valid/ready handshake and results leave over another.

Parameters:
- WIDTH, 32, data width. Only 32 is supported.
- SHAMT_W, 5, shift-amount width. Must equal log2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  32  value to shift.
- in_shamt  input  5  shift amount, 0..31.
- in_op  input  2  00=sll, 01=srl, 10=sra, 11=reserved.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  shifted result.
- out_err  output  1  result came from the reserved op.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset (asynchronous, while reset_n=0):
  - state=IDLE.
  - data, shamt, op and stage index registers = 0.
  - Outputs: out_valid=0, out_data=0x00000000, out_err=0, busy=0, in_ready=1.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). It is decoded from registered state only, with no combinational path from any input.
- IDLE:
  - Accept occurs on an edge with in_valid && in_ready. At accept, latch in_data, in_shamt and in_op, and set stage index = 0.
  - If in_op==11: state goes to DONE with out_data = in_data unchanged and out_err=1.
  - Else if in_shamt==0: state goes to DONE with out_data = in_data and out_err=0.
  - Otherwise state goes to SHIFT.
- SHIFT, once per clock at stage index k (0..4):
  - If shamt[k]=1, data is shifted by 2^k:
    - sll: zero fill from the LSB side.
    - srl: zero fill from the MSB side.
    - sra: fill with the MSB of the current data.
  - If shamt[k]=0, data is held.
  - If shamt bits above k are all zero: go to DONE.
  - Else: k increments and the state stays in SHIFT.
  - Trailing zero stages are skipped; leading and interior zero stages still cost one cycle each.
- DONE:
  - out_valid=1, and out_data/out_err hold the registered result.
  - On the edge with out_valid && out_ready, go to IDLE and clear out_valid.
  - While out_ready=0, out_data and out_err stay stable and no new operand is accepted.
- Latency L, counted from the accept cycle to the first cycle with out_valid=1:
  - shamt==0 or op==11: L=1.
  - Otherwise L = msb(shamt) + 2. Example: shamt=31 gives L=6.
- No overlap: at most one operation in flight. Earliest re-accept is the cycle after the output handshake.
- out_data is registered (never combinational) and is driven only in DONE. Outside DONE it holds its last value and must not be sampled; only out_valid qualifies it.
- Inputs presented while in_ready=0 are ignored and are not latched.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation, drops the result, and restores all reset values immediately. After release the block is in IDLE with in_ready=1.
- Arithmetic: the result must equal the Verilog operators for in_shamt 0..31:
  - sll: in_data << in_shamt.
  - srl: in_data >> in_shamt.
  - sra: $signed(in_data) >>> in_shamt.

Test Plan:
1. sll, in_data=0x00000001, shamt=4 -> SHIFT for 3 cycles, out_valid in cycle 4 after accept (L=5 counting from accept as cycle 0 is wrong; L = msb+2 = 4), out_data=0x00000010, out_err=0.
2. sra, in_data=0x80000000, shamt=31 -> L=6, out_data=0xFFFFFFFF. Then srl with the same operands -> out_data=0x00000001.
3. sll, in_data=0xDEADBEEF, shamt=0 -> L=1, out_data=0xDEADBEEF, SHIFT state never entered.
4. Backpressure: sll of 0x0000000F by 8 with out_ready=0 for 3 cycles -> out_valid stays 1, out_data=0x00000F00 stable, in_ready=0 throughout, and in_valid pulses during that time are ignored. After out_ready=1, in_ready=1 on the next cycle.
5. Reserved op 11, in_data=0x12345678, shamt=7 -> L=1, out_data=0x12345678, out_err=1.
6. Assert reset_n=0 during the 2nd SHIFT cycle of an sra with shamt=20 -> out_valid=0, out_data=0, busy=0, in_ready=1 immediately. After release, a new sll of 0x1 by 1 returns 0x00000002.
